// File: rtl/struct_pair_assembler_if.sv
// Field-write and record-read signals of struct_pair_assembler.
// The slave modport is the assembler side; master is the producer/consumer side.
interface struct_pair_assembler_if #(
  parameter int FIELD_W = 32,
  parameter int DEPTH   = 4
);
  logic                     a_valid;
  logic [FIELD_W-1:0]       a_data;
  logic                     a_dup;
  logic                     a_ready;
  logic                     b_valid;
  logic [FIELD_W-1:0]       b_data;
  logic                     b_ready;
  logic                     out_valid;
  logic                     out_ready;
  logic [2*FIELD_W-1:0]     out_data;
  logic [FIELD_W-1:0]       out_a;
  logic [$clog2(DEPTH):0]   count;

  modport slave (
    input  a_valid, a_data, a_dup, b_valid, b_data, out_ready,
    output a_ready, b_ready, out_valid, out_data, out_a, count
  );

  modport master (
    output a_valid, a_data, a_dup, b_valid, b_data, out_ready,
    input  a_ready, b_ready, out_valid, out_data, out_a, count
  );
endinterface

// File: rtl/struct_pair_assembler.sv
// Stages independently written a/b fields, commits complete {a, b} records
// into a DEPTH-entry FIFO and presents the head with valid/ready.
module struct_pair_assembler #(
  parameter int FIELD_W = 32,
  parameter int DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  struct_pair_assembler_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [FIELD_W-1:0] a;
    logic [FIELD_W-1:0] b;
  } rec_t;

  logic               a_held_q, a_held_d;
  logic               b_held_q, b_held_d;
  logic [FIELD_W-1:0] a_val_q, a_val_d;
  logic [FIELD_W-1:0] b_val_q, b_val_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  rec_t               mem_q [DEPTH];

  logic commit, pop, a_free, b_free, a_acc, dup_acc, b_acc, out_valid;
  rec_t head;

  // A slot being committed this cycle can be refilled in the same cycle.
  assign commit  = a_held_q && b_held_q && (count_q != FULL);
  assign a_free  = !a_held_q || commit;
  assign b_free  = !b_held_q || commit;

  assign bus.a_ready = a_free && (!bus.a_dup || b_free);
  assign bus.b_ready = b_free && !(bus.a_valid && bus.a_dup);

  assign a_acc   = bus.a_valid && bus.a_ready;
  assign dup_acc = a_acc && bus.a_dup;
  assign b_acc   = bus.b_valid && bus.b_ready;

  assign out_valid = (count_q != '0);
  assign pop       = out_valid && bus.out_ready;
  assign head      = out_valid ? mem_q[rd_ptr_q] : '0;

  assign bus.out_valid = out_valid;
  assign bus.out_data  = head;
  assign bus.out_a     = head.a;
  assign bus.count     = count_q;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no latch is inferred.
    a_held_d = a_held_q;
    b_held_d = b_held_q;
    a_val_d  = a_val_q;
    b_val_d  = b_val_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (commit) begin
      a_held_d = 1'b0;
      b_held_d = 1'b0;
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    // A new accept overrides the clear-on-commit of its slot.
    if (a_acc) begin
      a_held_d = 1'b1;
      a_val_d  = bus.a_data;
    end
    if (dup_acc) begin
      b_held_d = 1'b1;
      b_val_d  = bus.a_data;
    end
    if (b_acc) begin
      b_held_d = 1'b1;
      b_val_d  = bus.b_data;
    end

    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);

    unique case ({commit, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      a_held_q <= 1'b0;
      b_held_q <= 1'b0;
      a_val_q  <= '0;
      b_val_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      a_held_q <= a_held_d;
      b_held_q <= b_held_d;
      a_val_q  <= a_val_d;
      b_val_q  <= b_val_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array has no reset; count gates out_data, so stale entries are never seen.
  always_ff @(posedge clk) begin
    if (commit) mem_q[wr_ptr_q] <= '{a: a_val_q, b: b_val_q};
  end
endmodule

// File: tb/tb_struct_pair_assembler.sv
// Scoreboard bench for struct_pair_assembler: drivers push expected records,
// a monitor pops and compares on every accepted output record.
module tb_struct_pair_assembler;
  localparam int FW = 32;
  localparam int DP = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [2*FW-1:0] sb [$];

  struct_pair_assembler_if #(.FIELD_W(FW), .DEPTH(DP)) bus ();

  struct_pair_assembler #(.FIELD_W(FW), .DEPTH(DP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out, required completion", name);
  endtask

  // Monitor: every record handed over must match the scoreboard head.
  initial begin
    logic [2*FW-1:0] exp;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_record: got %h, required none", bus.out_data);
        end else begin
          exp = sb.pop_front();
          check("rec_data", bus.out_data, exp);
          check("rec_a", bus.out_a, exp[2*FW-1:FW]);
        end
      end
    end
  end

  // Called just after a rising edge; keeps each requested field valid until accepted.
  task automatic send(input bit do_a, input bit do_b, input logic [FW-1:0] a, input logic [FW-1:0] b);
    bit ga, gb;
    int budget = 0;
    bus.a_valid = do_a; bus.a_data = a; bus.a_dup = 1'b0;
    bus.b_valid = do_b; bus.b_data = b;
    while ((bus.a_valid || bus.b_valid) && budget < 50) begin
      @(negedge clk);
      ga = bus.a_valid && bus.a_ready;
      gb = bus.b_valid && bus.b_ready;
      @(posedge clk); #1;
      if (ga) bus.a_valid = 1'b0;
      if (gb) bus.b_valid = 1'b0;
      budget++;
    end
    if (bus.a_valid || bus.b_valid) begin
      timeout("send_accept");
      bus.a_valid = 1'b0;
      bus.b_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int budget = 0;
    while ((sb.size() != 0 || bus.count != 0) && budget < 100) begin
      @(posedge clk); #1;
      budget++;
    end
    if (sb.size() != 0 || bus.count != 0) timeout("drain");
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.a_valid = 1'b0; bus.a_data = '0; bus.a_dup = 1'b0;
    bus.b_valid = 1'b0; bus.b_data = '0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset then idle
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_count", bus.count, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_a_ready", bus.a_ready, 1);
    check("rst_b_ready", bus.b_ready, 1);
    step();

    // Split fields: a in cycle 0, b in cycle 3, record visible in cycle 5
    sb.push_back(64'h0000_0001_0000_0002);
    bus.a_valid = 1'b1; bus.a_data = 32'h0000_0001;
    step();
    bus.a_valid = 1'b0;
    step();
    step();
    bus.b_valid = 1'b1; bus.b_data = 32'h0000_0002;
    step();
    bus.b_valid = 1'b0;
    @(negedge clk);
    check("split_not_yet_c4", bus.out_valid, 0);
    step();
    @(negedge clk);
    check("split_valid_c5", bus.out_valid, 1);
    wait_drain();

    // Duplicate write refuses a concurrent b write
    sb.push_back(64'hDEAD_BEEF_DEAD_BEEF);
    bus.a_valid = 1'b1; bus.a_dup = 1'b1; bus.a_data = 32'hDEAD_BEEF;
    bus.b_valid = 1'b1; bus.b_data = 32'h1234_5678;
    @(negedge clk);
    check("dup_b_ready", bus.b_ready, 0);
    check("dup_a_ready", bus.a_ready, 1);
    step();
    bus.a_valid = 1'b0; bus.a_dup = 1'b0; bus.b_valid = 1'b0;
    wait_drain();

    // Backpressure, saturation, full-with-pop and pointer wrap
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sb.push_back({32'(i), ~32'(i)});
      send(1'b1, 1'b1, 32'(i), ~32'(i));
    end
    sb.push_back({32'd5, ~32'd5});
    bus.a_valid = 1'b1; bus.a_data = 32'd5;
    bus.b_valid = 1'b1; bus.b_data = ~32'd5;
    step();
    @(negedge clk);
    check("bp_count_sat", bus.count, 4);
    check("bp_a_ready", bus.a_ready, 0);
    check("bp_b_ready", bus.b_ready, 0);
    step();
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("full_pop_count", bus.count, 4);
    check("full_pop_a_ready", bus.a_ready, 0);
    step();
    @(negedge clk);
    check("late_commit_count", bus.count, 3);
    check("late_commit_a_ready", bus.a_ready, 1);
    check("late_commit_b_ready", bus.b_ready, 1);
    step();
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    wait_drain();

    // Simultaneous push and pop at count 2
    bus.out_ready = 1'b0;
    sb.push_back(64'h0000_00A0_0000_00B0); send(1'b1, 1'b1, 32'hA0, 32'hB0);
    sb.push_back(64'h0000_00A1_0000_00B1); send(1'b1, 1'b1, 32'hA1, 32'hB1);
    step();
    sb.push_back(64'h0000_00A2_0000_00B2); send(1'b1, 1'b1, 32'hA2, 32'hB2);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("pp_count_before", bus.count, 2);
    step();
    @(negedge clk);
    check("pp_count_after", bus.count, 2);
    wait_drain();

    // Reset mid-stream discards queued and staged data
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(1'b1, 1'b1, 32'hC0 + 32'(i), 32'hD0 + 32'(i));
    send(1'b1, 1'b0, 32'hEE, 32'h0);
    @(negedge clk);
    check("pre_rst_count", bus.count, 3);
    step();
    rst = 1'b1;
    sb.delete();
    step();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_count", bus.count, 0);
    check("mid_rst_out_valid", bus.out_valid, 0);
    step();
    send(1'b0, 1'b1, 32'h0, 32'h66);
    repeat (3) step();
    @(negedge clk);
    check("post_rst_b_only", bus.count, 0);
    step();
    bus.out_ready = 1'b1;
    sb.push_back(64'h0000_0055_0000_0066);
    send(1'b1, 1'b0, 32'h55, 32'h0);
    wait_drain();

    check("sb_empty_end", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/struct_pair_assembler.md
# struct_pair_assembler

Assembles packed two-field records `{a, b}` from independently-written field streams and queues completed records in a DEPTH-entry FIFO with a valid/ready output. It is the sequential, parametrised successor to our combinational struct assign/create/extract path. Fields may be written separately, like per-field `.a` and `.b` assigns, or duplicated from one value, like `'{x, x}`. It sits between field-level producers and record-level consumers and adds buffering, backpressure and generic field width.

## Interface
Parameters:
- FIELD_W, 32, width of each field a and b (≥1).
- DEPTH, 4, FIFO entries; power of two, ≥2.

Record layout:
- Packed struct `{a, b}`, a is the first member.
- a occupies bits [2*FIELD_W-1:FIELD_W]; b occupies bits [FIELD_W-1:0].

Ports:
- Clocking: one clock; reset is synchronous and active-high.
  - clk  in  1  clock, all state on rising edge.
  - rst  in  1  synchronous active-high reset.
- Field a input:
  - a_valid  in  1  field-a write request.
  - a_data  in  FIELD_W  field-a value.
  - a_dup  in  1  with a_valid, write a_data into both a and b.
  - a_ready  out  1  field-a write accepted this cycle when high with a_valid.
- Field b input:
  - b_valid  in  1  field-b write request.
  - b_data  in  FIELD_W  field-b value.
  - b_ready  out  1  field-b write accepted this cycle when high with b_valid.
- Record output:
  - out_valid  out  1  FIFO head valid.
  - out_ready  in  1  consumer accepts head.
  - out_data  out  2*FIELD_W  head record `{a, b}`.
  - out_a  out  FIELD_W  head field a (= out_data[2*FIELD_W-1:FIELD_W]).
- Status:
  - count  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.

## Operation
Staging registers:
- Slot A: a_held flag plus a_val. Slot B: b_held flag plus b_val.
- commit = a_held && b_held && (count != DEPTH).
- a_free = !a_held || commit; b_free = !b_held || commit.

Ready and accept rules:
- a_ready = a_free && (!a_dup || b_free).
- b_ready = b_free && !(a_valid && a_dup).
- A duplicate write owns both slots, so a concurrent b write is refused.
- Normal a accept: a_val <= a_data, a_held <= 1.
- Duplicate accept: a_val <= a_data, b_val <= a_data, both held <= 1.
- b accept: b_val <= b_data, b_held <= 1.
- Each slot keeps its last value until the commit that consumes it.
- A held slot with no new accept clears on commit.

Commit and FIFO:
- Commit pushes `{a_val, b_val}` into the FIFO at the write pointer.
- Pop occurs when out_valid && out_ready. The read pointer advances; entries are not cleared.
- out_valid = (count != 0).
- out_data = head entry when out_valid, else all zeros. out_a follows out_data.
- count: +1 on push only, -1 on pop only, unchanged when both or neither occur.
- Pointers wrap modulo DEPTH.

Boundary conditions:
- FIFO full: commit is blocked even when a pop happens the same cycle. Commit occurs the next cycle.
  - Staged fields are held; a_ready and b_ready stay low for held slots.
- Empty FIFO with out_ready high: no pop, count stays 0.
- Data never passes through combinationally; a record is visible only after it is in the FIFO.
- Reset mid-operation discards staged fields and queued records without emitting them.

## Timing
Reset values, from the cycle after rst is sampled high:
- a_held = b_held = 0, count = 0, pointers = 0, out_valid = 0, out_data = 0, out_a = 0.
- a_ready = b_ready = 1, subject to the a_dup combinational terms.

Latency and throughput:
- Both fields accepted in cycle N → commit in cycle N+1 → out_valid in cycle N+2 (2 cycles).
- Sustained throughput is one record per cycle: a_free/b_free include commit, so a slot can be refilled in the commit cycle.
- a_ready and b_ready are combinational from state and from a_valid/a_dup only, never from out_ready.

## Test plan
- Reset then idle: after rst is released, check out_valid=0, count=0, out_data=0, a_ready=b_ready=1.
- Split fields: a=32'h0000_0001 in cycle 0, b=32'h0000_0002 in cycle 3.
  - Expect out_valid in cycle 5 with out_data=64'h0000_0001_0000_0002 and out_a=1.
- Duplicate: a_valid, a_dup, a_data=32'hDEAD_BEEF, with b_valid high in the same cycle.
  - Expect b_ready=0 and out_data=64'hDEAD_BEEF_DEAD_BEEF.
- Backpressure and wrap: out_ready=0, stream 6 records with a=i, b=~i (DEPTH=4).
  - Expect count to saturate at 4, a record staged with a_ready=b_ready=0.
  - Then assert out_ready: expect in-order drain of records 0..5 across pointer wrap, no loss or duplication.
- Simultaneous push and pop at count=2: expect count to stay 2 and order to be preserved.
  - Push while full with a concurrent pop: expect the commit delayed by one cycle.
- Reset mid-stream: with 3 records queued and a staged, assert rst for 1 cycle.
  - Expect count=0, out_valid=0, and the next record to be assembled solely from post-reset writes.
